// File: rtl/booth_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : booth_pkg
//  Description : Shared types and helpers for the radix-4 Booth multiplier:
//                FSM state encoding, Booth recoding operations, iteration
//                count and the 3-bit window decoder.
//  Revision    : 1.0  initial release
// ============================================================================
package booth_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Radix-4 recoded digit: 0, +1, +2, -1, -2 times the multiplicand.
    typedef enum logic [2:0] {
        ZERO = 3'd0,
        PM1  = 3'd1,
        PM2  = 3'd2,
        NM1  = 3'd3,
        NM2  = 3'd4
    } booth_op_t;

    // Operands are extended by 2 bits and two bits are retired per cycle.
    function automatic int iter_count(input int width);
        return (width + 2) / 2;
    endfunction

    // Decode {x[i+1], x[i], x[i-1]} into a recoded Booth digit.
    function automatic booth_op_t booth_decode(input logic [2:0] window);
        booth_op_t op;
        case (window)
            3'b001, 3'b010: op = PM1;
            3'b011:         op = PM2;
            3'b100:         op = NM2;
            3'b101, 3'b110: op = NM1;
            default:        op = ZERO;
        endcase
        return op;
    endfunction

endpackage : booth_pkg
`default_nettype wire

// File: rtl/booth_r4_sel.sv
`default_nettype none
// ============================================================================
//  Module      : booth_r4_sel
//  Description : Combinational partial-product selector. Picks 0, M, 2M, ~M
//                or ~2M (widened by two sign bits) from the Booth window and
//                flags a carry-in so that the adder completes the negation.
//  Ports       : window   [2:0]           Booth window {P_lo[1:0], guard}
//                m_ext    [EXT_WIDTH-1:0] extended multiplicand
//                addend   [EXT_WIDTH+1:0] selected addend
//                carry_in                 1 when addend is an inverted value
//  Revision    : 1.0  initial release
// ============================================================================
module booth_r4_sel
    import booth_pkg::*;
#(
    parameter int EXT_WIDTH = 34
) (
    input  logic [2:0]           window,
    input  logic [EXT_WIDTH-1:0] m_ext,
    output logic [EXT_WIDTH+1:0] addend,
    output logic                 carry_in
);

    booth_op_t              op;
    logic [EXT_WIDTH+1:0]   m_wide;
    logic [EXT_WIDTH+1:0]   m2_wide;

    assign op      = booth_decode(window);
    // m_ext is already extended according to the mode, so its MSB is the
    // true sign and plain sign extension is correct in both modes.
    assign m_wide  = {{2{m_ext[EXT_WIDTH-1]}}, m_ext};
    assign m2_wide = {m_ext[EXT_WIDTH-1], m_ext, 1'b0};

    always_comb begin
        addend   = '0;
        carry_in = 1'b0;
        case (op)
            PM1: addend = m_wide;
            PM2: addend = m2_wide;
            NM1: begin
                addend   = ~m_wide;
                carry_in = 1'b1;
            end
            NM2: begin
                addend   = ~m2_wide;
                carry_in = 1'b1;
            end
            default: begin
                addend   = '0;
                carry_in = 1'b0;
            end
        endcase
    end

endmodule : booth_r4_sel
`default_nettype wire

// File: rtl/booth_r4_multiplier.sv
`default_nettype none
// ============================================================================
//  Module      : booth_r4_multiplier
//  Description : Sequential radix-4 (modified Booth) multiplier producing a
//                2*WIDTH-bit product in (WIDTH+2)/2 iteration cycles, with
//                per-operation signed/unsigned mode.
//  Ports       : clk           clock, rising edge
//                reset_n       asynchronous active-low reset
//                op_start      start request (ignored while busy)
//                op_clear      synchronous clear, wins over op_start
//                signed_mode   1 = two's complement, 0 = unsigned
//                multiplicand  operand A [WIDTH-1:0]
//                multiplier    operand X [WIDTH-1:0]
//                op_busy       high while iterating
//                op_done       high while result is valid
//                result        product [2*WIDTH-1:0], zero unless op_done
//  Revision    : 1.0  initial release
// ============================================================================
module booth_r4_multiplier
    import booth_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 op_start,
    input  logic                 op_clear,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic                 op_busy,
    output logic                 op_done,
    output logic [2*WIDTH-1:0]   result
);

    localparam int W2    = WIDTH + 2;
    localparam int ITER  = iter_count(WIDTH);
    localparam int CNT_W = $clog2(ITER);
    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(ITER - 1);

    generate
        if ((WIDTH < 4) || ((WIDTH % 2) != 0)) begin : g_width_check
            $error("booth_r4_multiplier: WIDTH must be even and >= 4");
        end
    endgenerate

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t               state;
    state_t               state_next;
    logic [W2-1:0]        m_reg;
    logic [W2+1:0]        p_hi;
    logic [W2-1:0]        p_lo;
    logic                 guard;
    logic [CNT_W-1:0]     count;
    logic [2*WIDTH-1:0]   result_reg;

    // FSM control strobes
    logic                 do_clear;
    logic                 do_load;
    logic                 do_step;
    logic                 do_finish;

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    logic [W2-1:0]        ext_a;
    logic [W2-1:0]        ext_x;
    logic [W2+1:0]        addend;
    logic                 carry_in;
    logic [W2+1:0]        sum;
    logic [W2+1:0]        next_hi;
    logic [W2-1:0]        next_lo;
    logic [2*WIDTH-1:0]   product;

    // Unsigned operands are handled purely by zero extension; the Booth
    // datapath is always signed.
    assign ext_a = {{2{signed_mode & multiplicand[WIDTH-1]}}, multiplicand};
    assign ext_x = {{2{signed_mode & multiplier[WIDTH-1]}},   multiplier};

    booth_r4_sel #(
        .EXT_WIDTH (W2)
    ) u_sel (
        .window   ({p_lo[1:0], guard}),
        .m_ext    (m_reg),
        .addend   (addend),
        .carry_in (carry_in)
    );

    // Negation completes here: the selector supplies ~M / ~2M and carry_in.
    assign sum     = p_hi + addend + {{(W2+1){1'b0}}, carry_in};

    // Arithmetic shift right by 2 of {sum, p_lo, guard}.
    assign next_hi = {{2{sum[W2+1]}}, sum[W2+1:2]};
    assign next_lo = {sum[1:0], p_lo[W2-1:2]};

    // After the last shift the product occupies the low bits of {hi, lo}.
    assign product = {next_hi[WIDTH-3:0], next_lo};

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and control strobes
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state;
        do_clear   = 1'b0;
        do_load    = 1'b0;
        do_step    = 1'b0;
        do_finish  = 1'b0;
        if (op_clear) begin
            state_next = IDLE;
            do_clear   = 1'b1;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (op_start) begin
                        state_next = BUSY;
                        do_load    = 1'b1;
                    end
                end
                BUSY: begin
                    // op_start is deliberately not looked at here.
                    do_step = 1'b1;
                    if (count == LAST_COUNT) begin
                        state_next = DONE;
                        do_finish  = 1'b1;
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_reg      <= '0;
            p_hi       <= '0;
            p_lo       <= '0;
            guard      <= 1'b0;
            count      <= '0;
            result_reg <= '0;
        end else if (do_clear) begin
            m_reg      <= '0;
            p_hi       <= '0;
            p_lo       <= '0;
            guard      <= 1'b0;
            count      <= '0;
            result_reg <= '0;
        end else if (do_load) begin
            m_reg      <= ext_a;
            p_hi       <= '0;
            p_lo       <= ext_x;
            guard      <= 1'b0;
            count      <= '0;
            result_reg <= '0;
        end else if (do_step) begin
            p_hi  <= next_hi;
            p_lo  <= next_lo;
            guard <= p_lo[1];
            if (do_finish) begin
                count      <= '0;
                result_reg <= product;
            end else begin
                count <= count + CNT_W'(1);
            end
        end
    end

    assign op_busy = (state == BUSY);
    assign op_done = (state == DONE);
    assign result  = result_reg;

endmodule : booth_r4_multiplier
`default_nettype wire

// File: doc/booth_r4_multiplier.md
Name: booth_r4_multiplier

Overview:
Parametrised radix-4 (modified Booth) sequential multiplier. It produces a 2*WIDTH-bit product in (WIDTH+2)/2 iteration cycles, roughly half the cycles of a radix-2 design.
It adds a per-operation signed/unsigned mode, a busy flag and a well-defined clear/restart protocol.
It sits in the ALU/arithmetic cluster alongside the existing adders and shifters and uses the same op_start/op_clear/op_done handshake.

Parameters:
WIDTH, 32, operand width in bits; must be even and >= 4 (elaboration error otherwise).
ITER, (WIDTH+2)/2, derived localparam (not overridable); number of iteration cycles.

Ports:
clk  input  1  clock; all state updates on rising edge
reset_n  input  1  asynchronous active-low reset
op_start  input  1  start request; sampled on rising edge
op_clear  input  1  synchronous clear; priority over op_start
signed_mode  input  1  1 = two's-complement operands, 0 = unsigned; captured with op_start
multiplicand  input  WIDTH  operand A; captured with op_start
multiplier  input  WIDTH  operand X; captured with op_start
op_busy  output  1  high while iterating
op_done  output  1  high while result is valid; held until clear or restart
result  output  2*WIDTH  product A*X; zero unless op_done=1

Behaviour:
- Reset (reset_n=0, asynchronous): state=IDLE; op_busy=0; op_done=0; result=0; all internal registers 0.
- States: IDLE, BUSY, DONE.
- Priority per edge: op_clear, then op_start, then normal progress.
- op_clear=1 (any state): go to IDLE; op_busy=0, op_done=0, result=0, counter=0. This also applies when op_start=1 on the same edge.
- op_start=1 and op_clear=0 in IDLE or DONE:
  - Capture operands and mode.
  - Go to BUSY; op_busy=1.
  - op_done=0 on the same edge.
  - result reads 0 during BUSY.
- op_start=1 in BUSY: ignored, and the operation continues undisturbed.
- Operand extension: both operands are extended to W2=WIDTH+2 bits, sign-extended if signed_mode=1, zero-extended otherwise.
- Product register layout: {P_hi[W2+1:0], P_lo[W2-1:0], guard}.
  - Load: P_hi=0, P_lo = extended X, guard=0.
  - P_hi carries 2 extra bits so that +/-2M cannot overflow.
- Per iteration: decode {P_lo[1:0], guard}:
  - 000 or 111 -> +0
  - 001 or 010 -> +M
  - 011 -> +2M
  - 100 -> -2M
  - 101 or 110 -> -M
- After the add/subtract into P_hi, the whole register is shifted arithmetically right by 2; guard takes the old P_lo[1].
- Negation is done as invert + carry-in 1 inside the adder. No separate negate stage.
- Counter 0..ITER-1, incremented each BUSY cycle. On the edge that completes iteration ITER: state=DONE, op_busy=0, op_done=1, result = low 2*WIDTH bits of the final {P_hi,P_lo}.
- Latency: op_start sampled at edge 0; op_done=1 after edge ITER (17 for WIDTH=32, 5 for WIDTH=8).
- DONE: result and op_done are held indefinitely. op_start restarts; op_clear clears.
- Arithmetic: results are exact in both modes with no overflow possible. Unsigned mode is handled purely by the zero extension; there is no separate datapath.
- op_done and op_busy are never both 1.

Decomposition:
- Package booth_pkg:
  - state enum (IDLE/BUSY/DONE);
  - booth op encoding (ZERO, PM1, PM2, NM1, NM2);
  - function iter_count(width).
- One sub-module, booth_r4_sel: combinational.
  - Inputs: 3-bit window and extended M.
  - Outputs: the selected addend (0/M/2M/~M/~2M) and the carry-in.
  - Unit-testable on its own.
- The top level holds the FSM, counter, adder and shift.

Test Plan:
- WIDTH=32, signed_mode=1, A=7, X=-3 (0xFFFFFFFD), op_start one cycle -> op_busy=1 for 17 cycles; op_done=1 after edge 17; result=0xFFFFFFFF_FFFFFFEB.
- WIDTH=32, signed_mode=0, A=X=0xFFFFFFFF -> result=0xFFFFFFFE_00000001. The same operands with signed_mode=1 -> result=0x00000000_00000001.
- WIDTH=32, signed_mode=1, A=X=0x80000000 -> result=0x40000000_00000000. Then pulse op_start with A=3, X=5 while in DONE -> op_done drops on that edge; 17 edges later result=15.
- Start A=100, X=200. At edge 5: pulse op_start with A=1, X=1 -> ignored. Final result=20000 at edge 17. Next op: assert op_clear and op_start together mid-BUSY -> IDLE, result=0, op_done=0, op_busy=0.
- Deassert reset_n asynchronously mid-BUSY (between edges) -> op_busy, op_done and result go to 0 immediately. After release, a fresh op (A=2, X=2) completes with result=4.
- WIDTH=8 instance, signed_mode=1, A=-128 (0x80), X=127 (0x7F) -> op_done after edge 5, result=0xC080. With signed_mode=0, A=0xFF, X=0xFF -> result=0xFE01.
